// File: rtl/hx711_reader.sv
// hx711_reader: serial reader for the HX711 load-cell ADC behind a 4-register
// Avalon-MM slave. It synchronises DOUT, generates PD_SCK, shifts in 24-bit
// two's-complement samples MSB first, then issues 1-3 extra pulses to select
// the gain/channel for the next conversion.
// Optional build macro: HX711_IRQ_EN adds the irq port and the CTRL.IRQ_EN bit.
module hx711_reader #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        hx711_dt,
`ifdef HX711_IRQ_EN
  output logic        irq,
`endif
  output logic        hx711_sck
);

  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned BIT_W    = 5;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned COUNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic                  dt_meta;
  logic                  dt_s;
  logic [DIV_W-1:0]      div_q;
  logic [BIT_W-1:0]      bit_q;
  logic [BIT_W-1:0]      npulse_q;
  logic [SAMPLE_W-1:0]   shreg_q;
  logic [SAMPLE_W-1:0]   data_q;
  logic [COUNT_W-1:0]    count_q;
  logic                  valid_q;
  logic                  ovr_q;
  logic                  armed_q;
  logic                  ctrl_en_q;
  logic [1:0]            ctrl_gain_q;
  logic                  irq_en_q;

  logic                  phase_last_c;
  logic                  start_c;
  logic                  shift_c;
  logic                  done_c;
  logic                  rd_data_c;
  logic                  wr_ctrl_c;
  logic                  busy_c;
  logic                  valid_c;
  logic                  ovr_c;
  logic [31:0]           reg_mux_c;
  logic                  unused_c;

  // Pulse count per conversion: 24 data bits plus gain/channel select pulses
  function automatic logic [BIT_W-1:0] pulses_for(input logic [1:0] gain);
    case (gain)
      2'b01:   pulses_for = BIT_W'(26);
      2'b10:   pulses_for = BIT_W'(27);
      default: pulses_for = BIT_W'(25);
    endcase
  endfunction

  assign phase_last_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign shift_c      = (state_q == S_HIGH) && phase_last_c && (bit_q < BIT_W'(SAMPLE_W));
  assign done_c       = (state_q == S_DONE);
  assign rd_data_c    = read && (address == 2'd0);
  assign wr_ctrl_c    = write && (address == 2'd2);
  assign busy_c       = (state_q != S_IDLE) && (state_q != S_WAIT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and conversion start strobe
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_en_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!ctrl_en_q) begin
          state_d = S_IDLE;
        end else if (armed_q && !dt_s) begin
          state_d = S_HIGH;
          start_c = 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_last_c) state_d = S_LOW;
      end
      S_LOW: begin
        if (phase_last_c) begin
          state_d = ((bit_q + BIT_W'(1)) == npulse_q) ? S_DONE : S_HIGH;
        end
      end
      S_DONE: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A new sample outranks a simultaneous DATA read; otherwise the read clears the flags
  always_comb begin
    valid_c = valid_q;
    ovr_c   = ovr_q;
    if (done_c) begin
      valid_c = 1'b1;
      if (valid_q && !rd_data_c) ovr_c = 1'b1;
    end else if (rd_data_c) begin
      valid_c = 1'b0;
      ovr_c   = 1'b0;
    end
  end

  // Register read multiplexer
  always_comb begin
    reg_mux_c = '0;
    case (address)
      2'd0:    reg_mux_c = {{(32 - SAMPLE_W){data_q[SAMPLE_W-1]}}, data_q};
      2'd1:    reg_mux_c = {28'd0, dt_s, ovr_q, busy_c, valid_q};
      2'd2:    reg_mux_c = {28'd0, irq_en_q, ctrl_gain_q, ctrl_en_q};
      default: reg_mux_c = {16'd0, count_q};
    endcase
  end

  // DT synchroniser, SCK timing, shifter, sample registers and bus read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dt_meta     <= 1'b0;
      dt_s        <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      npulse_q    <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      armed_q     <= 1'b1;
      ctrl_en_q   <= 1'b0;
      ctrl_gain_q <= 2'b00;
      hx711_sck   <= 1'b0;
      readdata    <= '0;
    end else begin
      dt_meta <= hx711_dt;
      dt_s    <= dt_meta;

      if (((state_q == S_HIGH) || (state_q == S_LOW)) && (state_d == state_q)) begin
        div_q <= div_q + DIV_W'(1);
      end else begin
        div_q <= '0;
      end

      if (start_c) begin
        bit_q    <= '0;
        npulse_q <= pulses_for(ctrl_gain_q);
      end else if ((state_q == S_LOW) && phase_last_c) begin
        bit_q <= bit_q + BIT_W'(1);
      end

      if (shift_c) shreg_q <= {shreg_q[SAMPLE_W-2:0], dt_s};

      // SCK is high exactly while the FSM sits in HIGH
      hx711_sck <= (state_d == S_HIGH);

      // DOUT must be seen high after a read before a low is taken as "ready"
      if (done_c) begin
        armed_q <= 1'b0;
      end else if (dt_s) begin
        armed_q <= 1'b1;
      end

      if (wr_ctrl_c) begin
        ctrl_en_q   <= writedata[0];
        ctrl_gain_q <= writedata[2:1];
      end

      if (done_c) begin
        data_q  <= shreg_q;
        count_q <= count_q + COUNT_W'(1);
      end
      valid_q <= valid_c;
      ovr_q   <= ovr_c;

      readdata <= read ? reg_mux_c : '0;
    end
  end

`ifdef HX711_IRQ_EN
  // Interrupt enable bit and level interrupt tracking VALID
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl_c) irq_en_q <= writedata[3];
      irq <= valid_c & (wr_ctrl_c ? writedata[3] : irq_en_q);
    end
  end
  assign unused_c = ^writedata[31:4];
`else
  assign irq_en_q = 1'b0;
  assign unused_c = ^writedata[31:3];
`endif

endmodule

// File: tb/tb_hx711_reader.sv
// Bench for hx711_reader: HX711 DOUT model, register-level reference model,
// one compare process for bus reads and SCK high-phase length.
module tb_hx711_reader;

  // Smallest divider at which the 2-flop DT synchroniser delay fits in the SCK high phase
  localparam int unsigned CLK_DIV = 3;
`ifdef HX711_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        dt;
  logic        sck;
`ifdef HX711_IRQ_EN
  logic        irq;
`endif

  hx711_reader #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .hx711_dt  (dt),
`ifdef HX711_IRQ_EN
    .irq       (irq),
`endif
    .hx711_sck (sck)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model of the register file
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ovr;
  logic [15:0] m_count;
  logic [3:0]  m_ctrl;

  // Pending read handed to the compare process
  int          rd_seq = 0;
  int          seen_seq = 0;
  logic [31:0] rd_exp;
  string       rd_name;
  int          hi_run = 0;
  int          cv_edges = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_reg(input logic [1:0] a);
    case (a)
      2'd0:    exp_reg = {{8{m_data[23]}}, m_data};
      2'd1:    exp_reg = {28'd0, dt, m_ovr, 1'b0, m_valid};
      2'd2:    exp_reg = {28'd0, m_ctrl};
      default: exp_reg = {16'd0, m_count};
    endcase
  endfunction

  function automatic int gain_pulses(input logic [1:0] g);
    if (g == 2'b01) return 26;
    if (g == 2'b10) return 27;
    return 25;
  endfunction

  task automatic model_reset();
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_count = '0; m_ctrl = '0;
  endtask

  task automatic model_sample(input logic [23:0] s);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = s;
    m_count = m_count + 16'd1;
  endtask

  // Compare process: bus read data and SCK high-phase length
  always @(negedge clk) begin
    if (rd_seq != seen_seq) begin
      seen_seq = rd_seq;
      check(rd_name, readdata, rd_exp);
    end
    if (!reset_n) begin
      hi_run = 0;
    end else if (sck) begin
      hi_run++;
    end else if (hi_run != 0) begin
      check("sck_high_cycles", hi_run, CLK_DIV);
      hi_run = 0;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    write = 1'b0;
    if (a == 2'd2) m_ctrl = d[3:0] & CTRL_MASK;
  endtask

  task automatic bus_read(input logic [1:0] a, input string name);
    @(posedge clk); #1;
    read = 1'b1; address = a;
    rd_exp = exp_reg(a);
    @(posedge clk); #1;
    read = 1'b0;
    rd_name = name;
    rd_seq++;
    if (a == 2'd0) begin m_valid = 1'b0; m_ovr = 1'b0; end
    @(negedge clk);
  endtask

  // Read with a hand-computed value that also pins the model
  task automatic bus_read_lit(input logic [1:0] a, input string name, input logic [31:0] lit);
    check({"model_", name}, exp_reg(a), lit);
    bus_read(a, name);
  endtask

  // HX711 model: pull DOUT low, present bit 23-n on rising edge n, DOUT high after the 24th
  task automatic convert(input logic [23:0] s, output int pulses);
    int guard;
    int idle;
    logic prev;
    guard = 0; idle = 0;
    repeat ($urandom_range(1, 6)) @(posedge clk);
    #1;
    prev = sck;
    dt = 1'b0;
    while (idle < int'(12 * CLK_DIV) && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
      if (sck && !prev) begin
        cv_edges++;
        dt = (cv_edges <= 24) ? s[24 - cv_edges] : 1'b1;
        idle = 0;
      end else if (!sck && cv_edges > 0) begin
        idle++;
      end
      prev = sck;
    end
    if (guard >= 4000) check("convert_timeout", guard, 0);
    dt = 1'b1;
    pulses = cv_edges;
  endtask

  task automatic run_conv(input logic [23:0] s, input string name);
    int p;
    cv_edges = 0;
    convert(s, p);
    check({name, "_pulses"}, p, gain_pulses(m_ctrl[2:1]));
    model_sample(s);
  endtask

  task automatic watch_sck_low(input int n, input string name);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (sck) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  initial begin
    logic [23:0] s;
    int p;
    logic [1:0] g;
    int guard;

    reset_n = 1'b0; dt = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", sck, 0);
    check("rst_readdata", readdata, 0);
    dt = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    watch_sck_low(20, "idle_sck");
    bus_read_lit(2'd1, "status_idle", 32'h8);

    // Gain A/128, positive full scale
    bus_write(2'd2, 32'h1);
    run_conv(24'h7FFFFF, "conv_pos");
    bus_read_lit(2'd1, "status_valid", 32'h9);
    bus_read_lit(2'd3, "count_one", 32'h1);
    bus_read_lit(2'd0, "data_pos", 32'h007FFFFF);
    bus_read_lit(2'd1, "status_cleared", 32'h8);

    // Gain A/64, negative sample
    bus_write(2'd2, 32'h5);
    run_conv(24'h800001, "conv_neg");
    bus_read_lit(2'd0, "data_neg", 32'hFF800001);
    bus_read_lit(2'd1, "status_after_read", 32'h8);

    // Overrun: two conversions without a DATA read
    bus_write(2'd2, 32'h3);
    run_conv(24'($urandom), "conv_ovr1");
    s = 24'($urandom);
    run_conv(s, "conv_ovr2");
    bus_read_lit(2'd1, "status_ovr", 32'hD);
    bus_read_lit(2'd0, "data_second", {{8{s[23]}}, s});
    bus_read_lit(2'd1, "status_ovr_cleared", 32'h8);

    // Random gains, samples and read patterns
    for (int i = 0; i < 10; i++) begin
      g = 2'($urandom_range(0, 3));
      bus_write(2'd2, {29'd0, g, 1'b1});
      run_conv(24'($urandom), "conv_rand");
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) bus_read(2'(k), "rand_read");
      end
    end
    bus_read(2'd3, "count_rand");
    bus_read(2'd0, "data_flush");

    // EN cleared during pulse 10: conversion completes, then FSM parks in IDLE
    bus_write(2'd2, 32'h1);
    s = 24'($urandom);
    cv_edges = 0;
    fork
      begin
        convert(s, p);
      end
      begin
        guard = 0;
        while (cv_edges < 10 && guard < 4000) begin
          @(posedge clk);
          guard++;
        end
        bus_write(2'd2, 32'h0);
      end
    join
    check("en_clear_pulses", p, 25);
    model_sample(s);
    dt = 1'b0;
    watch_sck_low(40, "en_clear_no_sck");
    bus_read_lit(2'd1, "status_en_clear", 32'h1);
    bus_read_lit(2'd0, "data_en_clear", {{8{s[23]}}, s});
    dt = 1'b1;
    repeat (4) @(posedge clk);

    // Leave VALID set and COUNT nonzero, then reset in the middle of an SCK high phase
    bus_write(2'd2, 32'h1);
    run_conv(24'($urandom), "conv_pre_reset");
    #1;
    dt = 1'b0;
    guard = 0;
    while (!sck && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reset_sck_seen_high", sck, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_sck_low", sck, 0);
    model_reset();
    dt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    bus_read_lit(2'd1, "status_post_reset", 32'h8);
    bus_read_lit(2'd3, "count_post_reset", 32'h0);
    bus_read_lit(2'd0, "data_post_reset", 32'h0);
    bus_read_lit(2'd2, "ctrl_post_reset", 32'h0);

    // IRQ enable bit handling
    bus_write(2'd2, 32'hB);
`ifdef HX711_IRQ_EN
    bus_read_lit(2'd2, "ctrl_irq", 32'hB);
    run_conv(24'($urandom), "conv_irq");
    check("irq_set", irq, m_valid & m_ctrl[3]);
    bus_read(2'd0, "data_irq");
    @(posedge clk); #1;
    check("irq_cleared", irq, 0);
`else
    bus_read_lit(2'd2, "ctrl_no_irq", 32'h3);
`endif
    bus_write(2'd2, 32'h0);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
